// File: rtl/ks_seq_pkg.sv
// Shared types and default sizing for the Karplus-Strong note sequencer.
package ks_seq_pkg;

  localparam int NUM_STEPS_DEF = 8;
  localparam int PERIOD_W_DEF  = 8;
  localparam int TEMPO_W_DEF   = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    PLAY = 2'd2
  } seq_state_e;

endpackage

// File: rtl/ks_seq_step_table.sv
// Step table register file: {rest, period} per step, resets to rests, write-through read.
module ks_seq_step_table
  import ks_seq_pkg::*;
#(
  parameter int NUM_STEPS = NUM_STEPS_DEF,
  parameter int PERIOD_W  = PERIOD_W_DEF,
  localparam int ADDR_W   = $clog2(NUM_STEPS)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                wr_en,
  input  logic [ADDR_W-1:0]   wr_addr,
  input  logic [PERIOD_W:0]   wr_data,
  input  logic [ADDR_W-1:0]   rd_addr,
  output logic [PERIOD_W:0]   rd_data
);

  logic [PERIOD_W:0] mem [NUM_STEPS];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_STEPS; i++) begin
        mem[i] <= {1'b1, {PERIOD_W{1'b0}}};
      end
    end else if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // A write landing on the address being read is forwarded so the reader sees it this clk.
  always_comb begin
    rd_data = mem[rd_addr];
    if (wr_en && (wr_addr == rd_addr)) begin
      rd_data = wr_data;
    end
  end

endmodule

// File: rtl/ks_note_sequencer.sv
// Steps through a table of string periods, plucking for a clamped number of sample ticks per step.
module ks_note_sequencer
  import ks_seq_pkg::*;
#(
  parameter int NUM_STEPS = NUM_STEPS_DEF,
  parameter int PERIOD_W  = PERIOD_W_DEF,
  parameter int TEMPO_W   = TEMPO_W_DEF,
  localparam int STEP_W   = $clog2(NUM_STEPS)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                sample_tick_i,
  input  logic                start_i,
  input  logic                stop_i,
  input  logic                loop_en_i,
  input  logic [TEMPO_W-1:0]  tempo_i,
  input  logic [7:0]          pluck_len_i,
  input  logic                wr_en_i,
  input  logic [STEP_W-1:0]   wr_addr_i,
  input  logic [PERIOD_W:0]   wr_data_i,
  output logic [PERIOD_W-1:0] period_o,
  output logic                pluck_o,
  output logic                busy_o,
  output logic [STEP_W-1:0]   step_o,
  output logic                done_o
);

  localparam int CMP_W = (TEMPO_W > 8) ? TEMPO_W : 8;

  function automatic logic [CMP_W-1:0] clamp_tempo(input logic [TEMPO_W-1:0] t);
    logic [CMP_W-1:0] te;
    te = CMP_W'(t);
    return (te < CMP_W'(2)) ? CMP_W'(2) : te;
  endfunction

  // Pluck must end at least one tick before the step does.
  function automatic logic [CMP_W-1:0] clamp_pluck(input logic [7:0] p,
                                                   input logic [CMP_W-1:0] te);
    logic [CMP_W-1:0] pe;
    pe = (p == 8'd0) ? CMP_W'(1) : CMP_W'(p);
    return (pe > (te - CMP_W'(1))) ? (te - CMP_W'(1)) : pe;
  endfunction

  seq_state_e          state_q, state_nxt;
  logic [STEP_W-1:0]   step_q, step_nxt;
  logic [PERIOD_W-1:0] period_q, period_nxt;
  logic                rest_q, rest_nxt;
  logic [TEMPO_W-1:0]  tick_q, tick_nxt;
  logic                pluck_q, pluck_nxt;
  logic                done_q, done_nxt;
  logic [PERIOD_W:0]   tbl_rd;
  logic [CMP_W-1:0]    tempo_eff, pluck_eff;

  ks_seq_step_table #(
    .NUM_STEPS (NUM_STEPS),
    .PERIOD_W  (PERIOD_W)
  ) u_table (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (wr_en_i),
    .wr_addr (wr_addr_i),
    .wr_data (wr_data_i),
    .rd_addr (step_q),
    .rd_data (tbl_rd)
  );

  assign tempo_eff = clamp_tempo(tempo_i);
  assign pluck_eff = clamp_pluck(pluck_len_i, tempo_eff);

  always_comb begin
    state_nxt  = state_q;
    step_nxt   = step_q;
    period_nxt = period_q;
    rest_nxt   = rest_q;
    tick_nxt   = tick_q;
    done_nxt   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start_i) begin
          step_nxt  = '0;
          state_nxt = LOAD;
        end
      end
      LOAD: begin
        period_nxt = tbl_rd[PERIOD_W-1:0];
        rest_nxt   = tbl_rd[PERIOD_W];
        tick_nxt   = '0;
        state_nxt  = PLAY;
      end
      PLAY: begin
        if (sample_tick_i) begin
          if (CMP_W'(tick_q) == (tempo_eff - CMP_W'(1))) begin
            if (step_q != STEP_W'(NUM_STEPS - 1)) begin
              step_nxt  = step_q + 1'b1;
              state_nxt = LOAD;
            end else if (loop_en_i) begin
              step_nxt  = '0;
              state_nxt = LOAD;
            end else begin
              state_nxt = IDLE;
              done_nxt  = 1'b1;
            end
          end else begin
            tick_nxt = tick_q + 1'b1;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase

    // Stop overrides everything, including a start or a step end in the same clk.
    if (stop_i) begin
      state_nxt  = IDLE;
      step_nxt   = step_q;
      period_nxt = period_q;
      rest_nxt   = rest_q;
      done_nxt   = 1'b0;
    end

    pluck_nxt = (state_nxt == PLAY) && !rest_nxt && (CMP_W'(tick_nxt) < pluck_eff);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      step_q   <= '0;
      period_q <= '0;
      rest_q   <= 1'b1;
      tick_q   <= '0;
      pluck_q  <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_nxt;
      step_q   <= step_nxt;
      period_q <= period_nxt;
      rest_q   <= rest_nxt;
      tick_q   <= tick_nxt;
      pluck_q  <= pluck_nxt;
      done_q   <= done_nxt;
    end
  end

  assign period_o = period_q;
  assign pluck_o  = pluck_q;
  assign busy_o   = (state_q != IDLE);
  assign step_o   = step_q;
  assign done_o   = done_q;

endmodule

// File: tb/tb_ks_note_sequencer.sv
// Randomized scoreboard bench: per-step expectations pushed at stimulus time, checked by a monitor.
module tb_ks_note_sequencer;

  localparam int NS = 8;
  localparam int PW = 8;
  localparam int TW = 16;

  logic          clk = 1'b0;
  logic          rst_n, sample_tick_i, start_i, stop_i, loop_en_i, wr_en_i;
  logic [TW-1:0] tempo_i;
  logic [7:0]    pluck_len_i;
  logic [2:0]    wr_addr_i;
  logic [PW:0]   wr_data_i;
  logic [PW-1:0] period_o;
  logic          pluck_o, busy_o, done_o;
  logic [2:0]    step_o;

  always #5 clk = ~clk;

  ks_note_sequencer #(.NUM_STEPS(NS), .PERIOD_W(PW), .TEMPO_W(TW)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .sample_tick_i (sample_tick_i),
    .start_i       (start_i),
    .stop_i        (stop_i),
    .loop_en_i     (loop_en_i),
    .tempo_i       (tempo_i),
    .pluck_len_i   (pluck_len_i),
    .wr_en_i       (wr_en_i),
    .wr_addr_i     (wr_addr_i),
    .wr_data_i     (wr_data_i),
    .period_o      (period_o),
    .pluck_o       (pluck_o),
    .busy_o        (busy_o),
    .step_o        (step_o),
    .done_o        (done_o)
  );

  typedef struct {
    bit is_done;
    bit partial;
    int step;
    int period;
    int pl;
    int tk;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   tbl_p[NS];
  bit   tbl_r[NS];
  bit   tick_en = 1'b0;

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, req);
    end
  endtask

  // Sample-rate ticks: never on consecutive clks, random gaps.
  initial begin
    int gap = 0;
    sample_tick_i = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (tick_en && gap == 0) begin
        sample_tick_i = 1'b1;
        gap = $urandom_range(1, 3);
      end else begin
        sample_tick_i = 1'b0;
        if (gap > 0) gap--;
      end
    end
  end

  task automatic finish_seg(input int s, input int per, input int pl, input int tk);
    exp_t e;
    if (sb.size() == 0) begin
      checks++; errors++;
      $display("FAIL unexpected_step: got step %0d expected none", s);
    end else begin
      e = sb.pop_front();
      check("seg_kind", 0, int'(e.is_done));
      check("seg_step", s, e.step);
      check("seg_period", per, e.period);
      if (!e.partial) begin
        check("seg_pluck_ticks", pl, e.pl);
        check("seg_ticks", tk, e.tk);
      end
    end
  endtask

  // Monitor: a step segment runs from busy rising or step_o changing until the next such event.
  initial begin
    bit   prev_busy = 1'b0, seg_act = 1'b0, first = 1'b0, b, pl_now, tk_now, dn;
    int   prev_step = 0, seg_step = 0, seg_per = 0, pl_cnt = 0, tk_cnt = 0, st;
    exp_t e;
    forever begin
      @(negedge clk);
      b = busy_o; pl_now = pluck_o; tk_now = sample_tick_i; dn = done_o; st = int'(step_o);
      if (b && (!prev_busy || st != prev_step)) begin
        if (seg_act) finish_seg(seg_step, seg_per, pl_cnt, tk_cnt);
        seg_act = 1'b1; first = 1'b1; seg_step = st; pl_cnt = 0; tk_cnt = 0;
      end else if (b) begin
        first = 1'b0;
        seg_per = int'(period_o);
        if (tk_now) begin
          tk_cnt++;
          if (pl_now) pl_cnt++;
        end
      end
      if (!b && prev_busy && seg_act) begin
        finish_seg(seg_step, seg_per, pl_cnt, tk_cnt);
        seg_act = 1'b0;
      end
      if (!b && rst_n) check("pluck_idle", int'(pl_now), 0);
      if (dn) begin
        if (sb.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_done: got done_o 1 expected 0");
        end else begin
          e = sb.pop_front();
          check("done_kind", int'(e.is_done), 1);
        end
      end
      prev_busy = b;
      prev_step = st;
    end
  end

  initial begin
    #800000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic clks(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic write_table();
    for (int i = 0; i < NS; i++) begin
      @(posedge clk); #1;
      wr_en_i = 1'b1; wr_addr_i = 3'(i); wr_data_i = {tbl_r[i], PW'(tbl_p[i])};
    end
    @(posedge clk); #1;
    wr_en_i = 1'b0;
  endtask

  // Reference: each step lasts max(tempo,2) ticks, plucks min(max(len,1),tempo_eff-1) ticks unless rest.
  task automatic push_steps(input int tempo, input int pl, input int first_k, input int n);
    int   te, pe;
    exp_t e;
    te = (tempo < 2) ? 2 : tempo;
    pe = (pl < 1) ? 1 : pl;
    if (pe > te - 1) pe = te - 1;
    for (int k = first_k; k < first_k + n; k++) begin
      e.is_done = 1'b0; e.partial = 1'b0; e.step = k % NS;
      e.period = tbl_p[k % NS]; e.pl = tbl_r[k % NS] ? 0 : pe; e.tk = te;
      sb.push_back(e);
    end
  endtask

  task automatic push_done();
    exp_t e;
    e.is_done = 1'b1; e.partial = 1'b0; e.step = 0; e.period = 0; e.pl = 0; e.tk = 0;
    sb.push_back(e);
  endtask

  task automatic push_partial(input int s);
    exp_t e;
    e.is_done = 1'b0; e.partial = 1'b1; e.step = s; e.period = tbl_p[s]; e.pl = 0; e.tk = 0;
    sb.push_back(e);
  endtask

  task automatic pulse_start();
    @(posedge clk); #1; start_i = 1'b1;
    @(posedge clk); #1; start_i = 1'b0;
  endtask

  task automatic wait_idle(input string nm);
    int n = 0;
    while (busy_o && n < 3000) begin @(posedge clk); #1; n++; end
    check(nm, int'(busy_o), 0);
  endtask

  task automatic wait_step(input string nm, input int s);
    int n = 0;
    while (!(busy_o && int'(step_o) == s) && n < 3000) begin @(posedge clk); #1; n++; end
    check(nm, int'(busy_o && int'(step_o) == s), 1);
  endtask

  task automatic full_run(input int tempo, input int pl);
    tempo_i = TW'(tempo); pluck_len_i = 8'(pl);
    write_table();
    push_steps(tempo, pl, 0, NS);
    push_done();
    pulse_start();
    wait_idle("run_end");
    clks(2);
  endtask

  initial begin
    rst_n = 1'b0; start_i = 1'b0; stop_i = 1'b0; loop_en_i = 1'b0;
    tempo_i = '0; pluck_len_i = '0; wr_en_i = 1'b0; wr_addr_i = '0; wr_data_i = '0;
    tick_en = 1'b1;
    clks(3);
    check("rst_period", int'(period_o), 0);
    check("rst_pluck", int'(pluck_o), 0);
    check("rst_busy", int'(busy_o), 0);
    check("rst_step", int'(step_o), 0);
    check("rst_done", int'(done_o), 0);
    rst_n = 1'b1;
    clks(2);

    // Basic playback, then outputs hold in IDLE.
    for (int i = 0; i < NS; i++) begin tbl_p[i] = 10 + i; tbl_r[i] = 1'b0; end
    full_run(4, 2);
    check("hold_step", int'(step_o), 7);
    check("hold_period", int'(period_o), 17);
    clks(5);
    check("hold_step_later", int'(step_o), 7);
    check("hold_period_later", int'(period_o), 17);
    check("hold_done", int'(done_o), 0);

    // Rest step and pluck clamping.
    tbl_p[3] = 20; tbl_r[3] = 1'b1;
    full_run(4, 9);

    // Randomized tables and timing, including tempo/pluck clamp corners.
    for (int r = 0; r < 5; r++) begin
      for (int i = 0; i < NS; i++) begin
        tbl_p[i] = $urandom_range(0, 255);
        tbl_r[i] = ($urandom_range(0, 3) == 0);
      end
      full_run($urandom_range(0, 6), $urandom_range(0, 9));
    end

    // Write to step 1 during its LOAD clk must be seen.
    for (int i = 0; i < NS; i++) begin tbl_p[i] = 40 + i; tbl_r[i] = 1'b0; end
    tempo_i = TW'(3); pluck_len_i = 8'd1;
    write_table();
    tbl_p[1] = 99;
    push_steps(3, 1, 0, NS);
    push_done();
    pulse_start();
    wait_step("bypass_step1", 1);
    wr_en_i = 1'b1; wr_addr_i = 3'd1; wr_data_i = {1'b0, 8'd99};
    @(posedge clk); #1;
    wr_en_i = 1'b0;
    wait_idle("bypass_end");
    clks(2);

    // Looping, then stop mid step 2.
    loop_en_i = 1'b1; tempo_i = TW'(4); pluck_len_i = 8'd2;
    push_steps(4, 2, 0, NS + 2);
    push_partial(2);
    pulse_start();
    wait_step("loop_step7", 7);
    wait_step("loop_wrap0", 0);
    wait_step("loop_step2", 2);
    clks(3);
    stop_i = 1'b1;
    @(posedge clk); #1;
    stop_i = 1'b0;
    check("stop_busy", int'(busy_o), 0);
    check("stop_pluck", int'(pluck_o), 0);
    check("stop_step", int'(step_o), 2);
    check("stop_period", int'(period_o), tbl_p[2]);
    check("stop_done", int'(done_o), 0);
    loop_en_i = 1'b0;
    clks(2);

    // Start and stop together: stop wins.
    @(posedge clk); #1; start_i = 1'b1; stop_i = 1'b1;
    @(posedge clk); #1; start_i = 1'b0; stop_i = 1'b0;
    check("startstop_busy", int'(busy_o), 0);
    check("startstop_step", int'(step_o), 2);
    clks(3);
    check("startstop_busy_later", int'(busy_o), 0);

    // Reset during PLAY aborts silently and clears the table to rests.
    tempo_i = TW'(3); pluck_len_i = 8'd1;
    push_steps(3, 1, 0, 3);
    push_partial(3);
    pulse_start();
    wait_step("rst_mid_step3", 3);
    clks(3);
    rst_n = 1'b0;
    @(posedge clk); #1;
    check("midrst_period", int'(period_o), 0);
    check("midrst_pluck", int'(pluck_o), 0);
    check("midrst_busy", int'(busy_o), 0);
    check("midrst_step", int'(step_o), 0);
    check("midrst_done", int'(done_o), 0);
    rst_n = 1'b1;
    clks(2);
    for (int i = 0; i < NS; i++) begin tbl_p[i] = 0; tbl_r[i] = 1'b1; end
    tempo_i = TW'(2); pluck_len_i = 8'd5;
    push_steps(2, 5, 0, NS);
    push_done();
    pulse_start();
    wait_idle("after_rst_end");
    clks(3);

    check("sb_empty", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
